// File: rtl/foc_vq_limiter_mc.sv
// Multi-channel FOC VQ limiter: LUT sin/cos fetch, time-shared Park transform,
// then per-channel current-based ceiling and slew limit on the VQ demand.

module foc_vq_ch #(
  parameter int DW     = 32,
  parameter int VQ_MAX = 4000,
  parameter int STEP   = 500,
  parameter int SLEW   = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lim_en,
  input  logic          over,
  input  logic          vq_en,
  input  logic          lock,
  input  logic [DW-1:0] vq_raw,
  output logic [DW-1:0] vq
);
  localparam logic signed [DW-1:0] LMAX  = DW'(VQ_MAX);
  localparam logic signed [DW-1:0] LSTEP = DW'(STEP);
  localparam logic signed [DW-1:0] LSLEW = DW'(SLEW);

  logic signed [DW-1:0] lim, vq_r, cmd;

  // SLEW runs the cycle after LIM, so cmd already sees the new limit
  assign cmd = ($signed(vq_raw) < lim) ? $signed(vq_raw) : lim;
  assign vq  = vq_r;

  always_ff @(posedge clk) begin
    if (rst) lim <= LMAX;
    else if (lim_en) begin
      if (over) lim <= (lim > LSTEP) ? lim - LSTEP : '0;
      else      lim <= (lim > LMAX - LSTEP) ? LMAX : lim + LSTEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || lock) vq_r <= '0;
    else if (vq_en) begin
      if (cmd > vq_r + LSLEW)      vq_r <= vq_r + LSLEW;
      else if (cmd < vq_r - LSLEW) vq_r <= vq_r - LSLEW;
      else                         vq_r <= cmd;
    end
  end
endmodule

module foc_vq_limiter_mc #(
  parameter int DW     = 32,
  parameter int AW     = 12,
  parameter int FRAC   = 15,
  parameter int CH     = 4,
  parameter int VSHIFT = 10,
  parameter int VQ_MAX = 4000,
  parameter int ILIM   = 6000,
  parameter int STEP   = 500,
  parameter int SLEW   = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ch_i,
  input  logic [AW-1:0]    angle_i,
  input  logic [DW-1:0]    ia_i,
  input  logic [DW-1:0]    ib_i,
  input  logic [DW-1:0]    pwm_i,
  input  logic [DW-1:0]    voltage_i,
  input  logic             lock_i,
  output logic             sin_req,
  output logic [AW-1:0]    sin_angle,
  input  logic             sin_vld,
  input  logic [DW-1:0]    sin_data,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    id_o,
  output logic [DW-1:0]    iq_o,
  output logic [CH*DW-1:0] vq_o
);
  localparam int PW = 2 * DW;
  localparam logic [AW-1:0]        QTR   = AW'(2 ** (AW - 2));
  localparam logic signed [PW-1:0] SMAX  = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN  = ~SMAX;
  localparam logic signed [DW-1:0] ILIMP = DW'(ILIM);

  typedef enum logic [3:0] {
    S_IDLE, S_SIN, S_COS, S_M1, S_M2, S_M3, S_M4, S_M5, S_ACC, S_LIM, S_SLEW
  } state_t;

  state_t state, state_n;

  logic [3:0]              ch_r;
  logic [AW-1:0]           ang_r;
  logic signed [DW-1:0]    ia_r, ib_r, s_r, c_r, id_n, iq_n;
  logic [DW-1:0]           pwm_r, volt_r, vq_raw, vq_raw_c;
  logic signed [PW-1:0]    opa, opb, prod, acc_d, acc_q;
  logic [PW-1:0]           pv_sh;
  logic                    accept, lut_hit, over;
  logic [CH-1:0][DW-1:0]   vq_ch;

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] sh;
    sh = x >>> FRAC;
    if (sh > SMAX)      sh = SMAX;
    else if (sh < SMIN) sh = SMIN;
    return sh[DW-1:0];
  endfunction

  assign busy    = (state != S_IDLE);
  assign lut_hit = sin_req && sin_vld;
  assign accept  = (state == S_IDLE) && (state_n == S_SIN);
  assign over    = (iq_n > ILIMP) || (iq_n < -ILIMP);
  assign pv_sh   = $unsigned(prod) >> VSHIFT;
  assign vq_raw_c = (pv_sh > PW'(VQ_MAX)) ? DW'(VQ_MAX) : pv_sh[DW-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start && ({1'b0, ch_i} < 5'(CH))) state_n = S_SIN;
      S_SIN:  if (lut_hit) state_n = S_COS;
      S_COS:  if (lut_hit) state_n = S_M1;
      S_M1:   state_n = S_M2;
      S_M2:   state_n = S_M3;
      S_M3:   state_n = S_M4;
      S_M4:   state_n = S_M5;
      S_M5:   state_n = S_ACC;
      S_ACC:  state_n = S_LIM;
      S_LIM:  state_n = S_SLEW;
      S_SLEW: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operands widened to 2*DW so signed and unsigned products share one multiplier
  always_comb begin
    opa = '0;
    opb = '0;
    case (state)
      S_M1: begin opa = PW'(ia_r); opb = PW'(c_r); end
      S_M2: begin opa = PW'(ib_r); opb = PW'(s_r); end
      S_M3: begin opa = PW'(ia_r); opb = PW'(s_r); end
      S_M4: begin opa = PW'(ib_r); opb = PW'(c_r); end
      S_M5: begin opa = $signed(PW'(pwm_r)); opb = $signed(PW'(volt_r)); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r <= '0; ang_r <= '0; ia_r <= '0; ib_r <= '0; pwm_r <= '0; volt_r <= '0;
      s_r <= '0; c_r <= '0; prod <= '0; acc_d <= '0; acc_q <= '0;
      id_n <= '0; iq_n <= '0; vq_raw <= '0; id_o <= '0; iq_o <= '0;
      sin_req <= 1'b0; sin_angle <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      prod <= opa * opb;
      if (accept) begin
        ch_r <= ch_i; ang_r <= angle_i; ia_r <= ia_i; ib_r <= ib_i;
        pwm_r <= pwm_i; volt_r <= voltage_i;
        sin_req <= 1'b1; sin_angle <= angle_i;
      end
      if (state == S_SIN && lut_hit) begin
        s_r <= sin_data;
        sin_angle <= ang_r + QTR;
      end
      if (state == S_COS && lut_hit) begin
        c_r <= sin_data;
        sin_req <= 1'b0;
      end
      // prod holds the product loaded in the previous state
      case (state)
        S_M2:  acc_d <= prod;
        S_M3:  acc_d <= acc_d + prod;
        S_M4:  acc_q <= -prod;
        S_M5:  acc_q <= acc_q + prod;
        S_ACC: begin id_n <= sat(acc_d); iq_n <= sat(acc_q); vq_raw <= vq_raw_c; end
        S_SLEW: begin id_o <= id_n; iq_o <= iq_n; done <= 1'b1; end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    foc_vq_ch #(.DW(DW), .VQ_MAX(VQ_MAX), .STEP(STEP), .SLEW(SLEW)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .lim_en (state == S_LIM  && ch_r == 4'(k)),
      .over   (over),
      .vq_en  (state == S_SLEW && ch_r == 4'(k)),
      .lock   (lock_i),
      .vq_raw (vq_raw),
      .vq     (vq_ch[k])
    );
  end

  assign vq_o = lock_i ? '0 : vq_ch;
endmodule

// File: tb/tb_foc_vq_limiter_mc.sv
// Bench for foc_vq_limiter_mc: directed and random updates against an
// arithmetic reference model, with a latency-programmable sine LUT.

module tb_foc_vq_limiter_mc;
  localparam int DW = 32, AW = 12, CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, start = 1'b0, lock_i = 1'b0;
  logic [3:0]       ch_i = '0;
  logic [AW-1:0]    angle_i = '0;
  logic [DW-1:0]    ia_i = '0, ib_i = '0, pwm_i = '0, voltage_i = '0;
  logic             sin_req, sin_vld = 1'b0, busy, done;
  logic [AW-1:0]    sin_angle;
  logic [DW-1:0]    sin_data = '0, id_o, iq_o;
  logic [CH*DW-1:0] vq_o;

  int tests = 0, fails = 0;
  int lut_lat = 1, lcnt = 0, a_hist0 = 0, a_hist1 = 0;
  int m_lim[CH], m_vq[CH];
  longint e_id, e_iq;

  foc_vq_limiter_mc dut (
    .clk(clk), .rst(rst), .start(start), .ch_i(ch_i), .angle_i(angle_i),
    .ia_i(ia_i), .ib_i(ib_i), .pwm_i(pwm_i), .voltage_i(voltage_i), .lock_i(lock_i),
    .sin_req(sin_req), .sin_angle(sin_angle), .sin_vld(sin_vld), .sin_data(sin_data),
    .busy(busy), .done(done), .id_o(id_o), .iq_o(iq_o), .vq_o(vq_o)
  );

  function automatic int lut(input int a);
    real ph;
    ph = 2.0 * 3.14159265358979 * real'(a) / 4096.0;
    return $rtoi($floor(32767.0 * $sin(ph) + 0.5));
  endfunction

  // LUT answers lut_lat cycles after a request is presented
  always @(posedge clk) begin
    if (!sin_req || sin_vld) begin
      sin_vld <= 1'b0;
      lcnt <= 0;
    end else if (lcnt >= lut_lat - 1) begin
      sin_vld <= 1'b1;
      sin_data <= lut(int'(sin_angle));
      a_hist0 <= a_hist1;
      a_hist1 <= int'(sin_angle);
    end else lcnt <= lcnt + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_vq(input int k);
    logic [DW-1:0] v;
    v = vq_o[k*DW +: DW];
    return longint'($signed(v));
  endfunction

  function automatic longint satv(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin m_lim[k] = 4000; m_vq[k] = 0; end
  endtask

  task automatic model(input int ch, input int a, input longint ia, input longint ib,
                       input longint pwm, input longint volt);
    longint s, c, raw, cmd;
    s = lut(a);
    c = lut((a + 1024) % 4096);
    e_id = satv((ia * c + ib * s) >>> 15);
    e_iq = satv((ib * c - ia * s) >>> 15);
    raw = (pwm * volt) >> 10;
    if (raw > 4000) raw = 4000;
    if (e_iq > 6000 || e_iq < -6000) m_lim[ch] = (m_lim[ch] - 500 < 0) ? 0 : m_lim[ch] - 500;
    else                             m_lim[ch] = (m_lim[ch] + 500 > 4000) ? 4000 : m_lim[ch] + 500;
    cmd = (raw < m_lim[ch]) ? raw : m_lim[ch];
    if (cmd > m_vq[ch] + 50)      m_vq[ch] = m_vq[ch] + 50;
    else if (cmd < m_vq[ch] - 50) m_vq[ch] = m_vq[ch] - 50;
    else                          m_vq[ch] = int'(cmd);
  endtask

  task automatic do_update(input int ch, input int a, input longint ia, input longint ib,
                           input longint pwm, input longint volt, input int lat,
                           input bit lk, input bit xs);
    int cyc, exp_cyc;
    bit got;
    lut_lat = lat;
    exp_cyc = 13 + 2 * (lat - 1);
    model(ch, a, ia, ib, pwm, volt);
    if (lk) for (int k = 0; k < CH; k++) m_vq[k] = 0;
    ch_i = 4'(ch); angle_i = AW'(a);
    ia_i = ia[DW-1:0]; ib_i = ib[DW-1:0]; pwm_i = pwm[DW-1:0]; voltage_i = volt[DW-1:0];
    start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++; start = 1'b0; lock_i = 1'b0;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (xs && cyc == 5) begin
        start = 1'b1; ch_i = 4'((ch + 1) % CH); angle_i = AW'($urandom);
      end
      if (lk && cyc == exp_cyc - 1) begin
        lock_i = 1'b1;
        #1;
        for (int k = 0; k < CH; k++) chk($sformatf("vq%0d_during_lock", k), get_vq(k), 0);
      end
      if (done) got = 1'b1;
    end
    chk("done_cycle", cyc, exp_cyc);
    chk("id", longint'($signed(id_o)), e_id);
    chk("iq", longint'($signed(iq_o)), e_iq);
    for (int k = 0; k < CH; k++) chk($sformatf("vq%0d", k), get_vq(k), m_vq[k]);
    chk("sin_addr", a_hist0, a);
    chk("cos_addr", a_hist1, (a + 1024) % 4096);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
  endtask

  initial begin
    int seen, bsy;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sin_req", sin_req, 0);
    chk("rst_sin_angle", sin_angle, 0);
    chk("rst_id", id_o, 0);
    chk("rst_iq", iq_o, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < CH; k++) chk($sformatf("rst_vq%0d", k), get_vq(k), 0);

    // Park transform at cardinal angles
    do_update(0, 0, 1000, 0, 0, 0, 1, 0, 0);
    chk("id_angle0", longint'($signed(id_o)), 999);
    chk("iq_angle0", longint'($signed(iq_o)), 0);
    do_update(0, 1024, 1000, 0, 0, 0, 1, 0, 0);
    chk("iq_angle1024", longint'($signed(iq_o)), -1000);
    chk("cos_addr_1024", a_hist1, 2048);
    do_update(0, 3072, 1000, 0, 0, 0, 1, 0, 0);
    chk("cos_addr_wrap", a_hist1, 0);

    // Slew ramp on ch1, then lock during its SLEW cycle
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 0, 0);
    chk("vq1_ramp1", get_vq(1), 50);
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 0, 0);
    chk("vq1_ramp2", get_vq(1), 100);
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 0, 0);
    chk("vq1_ramp3", get_vq(1), 150);
    chk("vq0_idle", get_vq(0), 0);
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 1, 0);
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 0, 1);
    chk("vq1_after_lock", get_vq(1), 50);

    // Out-of-range channel is ignored
    ch_i = 4'd5; start = 1'b1; seen = 0; bsy = 0;
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
      if (busy) bsy = 1;
    end
    chk("ch5_no_busy", bsy, 0);
    chk("ch5_no_done", seen, 0);

    // Overcurrent on ch2 drives its limit to zero, then it recovers
    for (int i = 0; i < 10; i++) begin
      do_update(2, 1024, -7000, 0, 1000, 2048, 1, 0, 0);
      if (i == 0) chk("iq_overcurrent", longint'($signed(iq_o)), 6999);
    end
    for (int i = 0; i < 4; i++) do_update(2, 1024, 0, 0, 1000, 2048, 1, 0, 0);

    // Randomised updates
    for (int i = 0; i < 40; i++)
      do_update($urandom_range(0, CH - 1), $urandom_range(0, 4095),
                longint'($urandom_range(0, 40000)) - 20000,
                longint'($urandom_range(0, 40000)) - 20000,
                $urandom_range(0, 4000), $urandom_range(0, 2048),
                $urandom_range(1, 3), 0, 0);

    // Slow LUT
    do_update(3, 512, 3000, -2000, 2000, 1500, 5, 0, 0);

    // Reset mid-update aborts with no done
    lut_lat = 5; ch_i = 4'd0; angle_i = '0; start = 1'b1;
    for (int cy = 1; cy <= 6; cy++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sin_req", sin_req, 0);
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    for (int k = 0; k < CH; k++) chk($sformatf("abort_vq%0d", k), get_vq(k), 0);
    do_update(1, 0, 1000, 0, 1000, 2048, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
